// File: rtl/interrupt_ctrl_nch.sv
// interrupt_ctrl_nch: multi-channel interrupt controller with per-channel
// synchronisers, edge/level and polarity select, pending latches, masking,
// lowest-index priority and an IRQ/ACK/EOI handshake to one consumer.
//
// Ports:
//   CLK      rising-edge clock
//   nRST     asynchronous active-low reset
//   EN       global enable; low forces IDLE and blocks new pending sets
//   INTR_IN  raw interrupt sources (may be asynchronous)
//   MASK     1 = channel may raise a request
//   ACK      consumer accepts the current request (honoured in REQ only)
//   EOI      consumer ends service (honoured in SERVICE only)
//   IRQ      registered request to the consumer
//   IRQ_ID   registered channel index of the current request/service
//   BUSY     registered: a request is in service
//   PENDING  edge latches plus live (enable-gated) level states

module interrupt_ctrl_nch #(
    parameter int                    C_CHANNELS    = 8,
    parameter int                    C_SYNC_STAGES = 2,
    parameter logic [C_CHANNELS-1:0] C_EDGE_MASK   = '1,
    parameter logic [C_CHANNELS-1:0] C_ACTIVE_MASK = '1,
    localparam int                   C_ID_W        =
        (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  EN,
    input  logic [C_CHANNELS-1:0] INTR_IN,
    input  logic [C_CHANNELS-1:0] MASK,
    input  logic                  ACK,
    input  logic                  EOI,
    output logic                  IRQ,
    output logic [C_ID_W-1:0]     IRQ_ID,
    output logic                  BUSY,
    output logic [C_CHANNELS-1:0] PENDING
);

    // Raw level that counts as "inactive" for each channel.
    localparam logic [C_CHANNELS-1:0] IDLE_LVL = ~C_ACTIVE_MASK;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SRV
    } state_t;

    logic [C_CHANNELS-1:0] sync_w;
    logic [C_CHANNELS-1:0] act_w;
    logic [C_CHANNELS-1:0] prev_q;
    logic [C_CHANNELS-1:0] edge_w;
    logic [C_CHANNELS-1:0] set_w;
    logic [C_CHANNELS-1:0] clr_w;
    logic [C_CHANNELS-1:0] pend_q;
    logic [C_CHANNELS-1:0] pend_d;
    logic [C_CHANNELS-1:0] req_w;
    logic [C_ID_W-1:0]     win_w;
    logic                  ack_fire_w;

    state_t                state_q;
    logic                  irq_q;
    logic                  busy_q;
    logic [C_ID_W-1:0]     id_q;

    // Synchroniser chain; stages reset to the inactive level so an input
    // held active through reset produces one clean edge after release.
    generate
        if (C_SYNC_STAGES == 0) begin : g_nosync
            assign sync_w = INTR_IN;
        end else begin : g_sync
            logic [C_CHANNELS-1:0] sync_q [C_SYNC_STAGES];

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    for (int i = 0; i < C_SYNC_STAGES; i++) begin
                        sync_q[i] <= IDLE_LVL;
                    end
                end else begin
                    sync_q[0] <= INTR_IN;
                    for (int i = 1; i < C_SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign sync_w = sync_q[C_SYNC_STAGES-1];
        end
    endgenerate

    // Normalise polarity: 1 means active for every channel.
    assign act_w  = sync_w ^ IDLE_LVL;
    assign edge_w = act_w & ~prev_q & C_EDGE_MASK;
    assign set_w  = edge_w & {C_CHANNELS{EN}};

    assign ack_fire_w = (state_q == S_REQ) && EN && ACK;

    always_comb begin
        clr_w = '0;
        if (ack_fire_w) begin
            clr_w = (C_CHANNELS'(1) << id_q) & C_EDGE_MASK;
        end
    end

    // A new edge coinciding with ACK of the same channel must survive.
    assign pend_d = (pend_q & ~clr_w) | set_w;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= act_w;
            pend_q <= pend_d;
        end
    end

    // Level channels read straight from the flop behind the synchroniser.
    assign PENDING = pend_q
                   | (prev_q & ~C_EDGE_MASK & {C_CHANNELS{EN}});

    assign req_w = PENDING & MASK;

    // Lowest set index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        win_w = '0;
        for (int i = C_CHANNELS - 1; i >= 0; i--) begin
            if (req_w[i]) begin
                win_w = C_ID_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= '0;
        end else if (!EN) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|req_w) begin
                        state_q <= S_REQ;
                        irq_q   <= 1'b1;
                        id_q    <= win_w;
                    end
                end
                S_REQ: begin
                    if (ACK) begin
                        state_q <= S_SRV;
                        irq_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SRV: begin
                    if (EOI) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    irq_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign IRQ    = irq_q;
    assign BUSY   = busy_q;
    assign IRQ_ID = id_q;

endmodule

// File: tb/tb_interrupt_ctrl_nch.sv
// tb_interrupt_ctrl_nch: directed vector table, hand-written corner
// sequences and randomised traffic against a queue-based reference model.

module tb_interrupt_ctrl_nch;

    localparam int         N       = 8;
    localparam int         S       = 2;
    localparam logic [7:0] EDGE_M  = 8'hFE;
    localparam logic [7:0] ACT_M   = 8'hFE;
    localparam logic [7:0] IDLE_IN = 8'h01;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       EN = 1'b1;
    logic       ACK = 1'b0;
    logic       EOI = 1'b0;
    logic [7:0] INTR_IN = IDLE_IN;
    logic [7:0] MASK = 8'hFF;
    logic       IRQ;
    logic       BUSY;
    logic [2:0] IRQ_ID;
    logic [7:0] PENDING;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    interrupt_ctrl_nch #(
        .C_CHANNELS   (N),
        .C_SYNC_STAGES(S),
        .C_EDGE_MASK  (EDGE_M),
        .C_ACTIVE_MASK(ACT_M)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .EN     (EN),
        .INTR_IN(INTR_IN),
        .MASK   (MASK),
        .ACK    (ACK),
        .EOI    (EOI),
        .IRQ    (IRQ),
        .IRQ_ID (IRQ_ID),
        .BUSY   (BUSY),
        .PENDING(PENDING)
    );

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_REQ, M_SRV} mst_t;

    logic [7:0] mh[$];
    mst_t       m_st;
    int         m_id;
    logic [7:0] m_latch, m_lvl;
    logic [7:0] m_act, m_prv, m_rose, m_reqv, m_clr;

    function automatic int lowest(input logic [7:0] v);
        logic [7:0] iso;
        iso = v & (~v + 8'd1);
        return $clog2(iso);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mh = {};
            repeat (S + 2) mh.push_front(8'h00);
            m_st    = M_IDLE;
            m_id    = 0;
            m_latch = 8'h00;
            m_lvl   = 8'h00;
        end else begin
            m_reqv = (m_latch | (m_lvl & {8{EN}})) & MASK;
            mh.push_front(INTR_IN ^ ~ACT_M);
            void'(mh.pop_back());
            m_act  = mh[S];
            m_prv  = mh[S+1];
            m_rose = m_act & ~m_prv & EDGE_M & {8{EN}};
            m_clr  = 8'h00;
            case (m_st)
                M_IDLE: if (EN && m_reqv != 0) begin
                    m_st = M_REQ;
                    m_id = lowest(m_reqv);
                end
                M_REQ: if (!EN) m_st = M_IDLE;
                    else if (ACK) begin
                        m_st  = M_SRV;
                        m_clr = 8'(1 << m_id) & EDGE_M;
                    end
                M_SRV: if (!EN || EOI) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
            m_latch = (m_latch & ~m_clr) | m_rose;
            m_lvl   = m_act & ~EDGE_M;
        end
    end

    function automatic logic [31:0] model_exp();
        return {19'd0, m_st == M_REQ, 3'(m_id), m_st == M_SRV,
                m_latch | (m_lvl & {8{EN}})};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [31:0] obs();
        return {19'd0, IRQ, IRQ_ID, BUSY, PENDING};
    endfunction

    function automatic logic [31:0] pk(input logic i, input logic [2:0] id,
                                       input logic b, input logic [7:0] p);
        return {19'd0, i, id, b, p};
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (irq,id,busy,pend)",
                     nm, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] in, input logic [7:0] m,
                        input logic en, input logic a, input logic e);
        INTR_IN = in;
        MASK    = m;
        EN      = en;
        ACK     = a;
        EOI     = e;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [7:0] in;
        logic [7:0] mask;
        logic       en;
        logic       ack;
        logic       eoi;
        logic       irq;
        logic [2:0] id;
        logic       busy;
        logic [7:0] pend;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] in, input logic [7:0] m,
                                input logic a, input logic e,
                                input logic irq, input logic [2:0] id,
                                input logic b, input logic [7:0] p);
        vec_t v;
        v.in = in; v.mask = m; v.en = 1'b1; v.ack = a; v.eoi = e;
        v.irq = irq; v.id = id; v.busy = b; v.pend = p;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [2:0] lastid;
        logic [7:0] rin;
        logic [7:0] rmask;

        // single edge on 3
        tbl[0]  = mk(8'h09, 8'hFF, 0, 0, 0, 3'd0, 0, 8'h00);
        tbl[1]  = mk(8'h01, 8'hFF, 0, 0, 0, 3'd0, 0, 8'h00);
        tbl[2]  = mk(8'h01, 8'hFF, 0, 0, 0, 3'd0, 0, 8'h08);
        tbl[3]  = mk(8'h01, 8'hFF, 0, 0, 1, 3'd3, 0, 8'h08);
        tbl[4]  = mk(8'h01, 8'hFF, 1, 0, 0, 3'd3, 1, 8'h00);
        tbl[5]  = mk(8'h01, 8'hFF, 0, 0, 0, 3'd3, 1, 8'h00);
        tbl[6]  = mk(8'h01, 8'hFF, 0, 1, 0, 3'd3, 0, 8'h00);
        tbl[7]  = mk(8'h01, 8'hFF, 0, 0, 0, 3'd3, 0, 8'h00);
        // priority 5 vs 1
        tbl[8]  = mk(8'h23, 8'hFF, 0, 0, 0, 3'd3, 0, 8'h00);
        tbl[9]  = mk(8'h01, 8'hFF, 0, 0, 0, 3'd3, 0, 8'h00);
        tbl[10] = mk(8'h01, 8'hFF, 0, 0, 0, 3'd3, 0, 8'h22);
        tbl[11] = mk(8'h01, 8'hFF, 0, 0, 1, 3'd1, 0, 8'h22);
        tbl[12] = mk(8'h01, 8'hFF, 1, 0, 0, 3'd1, 1, 8'h20);
        tbl[13] = mk(8'h01, 8'hFF, 0, 1, 0, 3'd1, 0, 8'h20);
        tbl[14] = mk(8'h01, 8'hFF, 0, 0, 1, 3'd5, 0, 8'h20);
        tbl[15] = mk(8'h01, 8'hFF, 1, 1, 0, 3'd5, 1, 8'h00);
        tbl[16] = mk(8'h01, 8'hFF, 0, 1, 0, 3'd5, 0, 8'h00);
        tbl[17] = mk(8'h01, 8'hFF, 0, 0, 0, 3'd5, 0, 8'h00);
        // masked edge on 2
        tbl[18] = mk(8'h05, 8'hFB, 0, 0, 0, 3'd5, 0, 8'h00);
        tbl[19] = mk(8'h01, 8'hFB, 0, 0, 0, 3'd5, 0, 8'h00);
        tbl[20] = mk(8'h01, 8'hFB, 0, 0, 0, 3'd5, 0, 8'h04);
        tbl[21] = mk(8'h01, 8'hFB, 0, 0, 0, 3'd5, 0, 8'h04);
        tbl[22] = mk(8'h01, 8'hFF, 0, 0, 1, 3'd2, 0, 8'h04);
        tbl[23] = mk(8'h01, 8'hFF, 1, 0, 0, 3'd2, 1, 8'h00);
        tbl[24] = mk(8'h01, 8'hFF, 0, 1, 0, 3'd2, 0, 8'h00);
        tbl[25] = mk(8'h01, 8'hFF, 0, 0, 0, 3'd2, 0, 8'h00);

        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", obs(), pk(0, 0, 0, 8'h00));
        nRST = 1'b1;
        repeat (4) step(IDLE_IN, 8'hFF, 1, 0, 0);
        check("idle_after_reset", obs(), pk(0, 0, 0, 8'h00));

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].mask, tbl[i].en, tbl[i].ack, tbl[i].eoi);
            check($sformatf("tbl[%0d]", i), obs(),
                  pk(tbl[i].irq, tbl[i].id, tbl[i].busy, tbl[i].pend));
        end

        // level, active-low channel 0
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        check("lvl_sync", obs(), pk(0, 2, 0, 8'h00));
        step(8'h00, 8'hFF, 1, 0, 0);
        check("lvl_pend", obs(), pk(0, 2, 0, 8'h01));
        step(8'h00, 8'hFF, 1, 0, 0);
        check("lvl_irq", obs(), pk(1, 0, 0, 8'h01));
        step(8'h00, 8'hFF, 1, 1, 0);
        check("lvl_ack", obs(), pk(0, 0, 1, 8'h01));
        step(8'h00, 8'hFF, 1, 0, 1);
        check("lvl_eoi", obs(), pk(0, 0, 0, 8'h01));
        step(8'h00, 8'hFF, 1, 0, 0);
        check("lvl_rereq", obs(), pk(1, 0, 0, 8'h01));
        step(8'h01, 8'hFF, 1, 1, 0);
        step(8'h01, 8'hFF, 1, 0, 0);
        check("lvl_release_s", obs(), pk(0, 0, 1, 8'h01));
        step(8'h01, 8'hFF, 1, 0, 1);
        check("lvl_release_s1", obs(), pk(0, 0, 0, 8'h00));
        step(8'h01, 8'hFF, 1, 0, 0);
        check("lvl_quiet", obs(), pk(0, 0, 0, 8'h00));

        // edge on 4 coinciding with its own ACK
        step(8'h11, 8'hFF, 1, 0, 0);
        step(8'h01, 8'hFF, 1, 0, 0);
        step(8'h11, 8'hFF, 1, 0, 0);
        step(8'h01, 8'hFF, 1, 0, 0);
        check("col_irq", obs(), pk(1, 4, 0, 8'h10));
        step(8'h01, 8'hFF, 1, 1, 0);
        check("col_ack_set_wins", obs(), pk(0, 4, 1, 8'h10));
        step(8'h01, 8'hFF, 1, 0, 1);
        check("col_eoi", obs(), pk(0, 4, 0, 8'h10));
        step(8'h01, 8'hFF, 1, 0, 0);
        check("col_rereq", obs(), pk(1, 4, 0, 8'h10));
        step(8'h01, 8'hFF, 1, 1, 0);
        step(8'h01, 8'hFF, 1, 0, 1);
        check("col_done", obs(), pk(0, 4, 0, 8'h00));

        // EN dropped during REQ on 6
        step(8'h41, 8'hFF, 1, 0, 0);
        step(8'h01, 8'hFF, 1, 0, 0);
        step(8'h01, 8'hFF, 1, 0, 0);
        step(8'h01, 8'hFF, 1, 0, 0);
        check("en_req", obs(), pk(1, 6, 0, 8'h40));
        step(8'h01, 8'hFF, 0, 0, 0);
        check("en_off_idle", obs(), pk(0, 6, 0, 8'h40));
        step(8'h01, 8'hFF, 1, 0, 0);
        check("en_on_rereq", obs(), pk(1, 6, 0, 8'h40));
        step(8'h01, 8'hFF, 1, 1, 0);
        check("en_service", obs(), pk(0, 6, 1, 8'h00));

        // async reset during SERVICE, then input held active through it
        #2;
        nRST = 1'b0;
        #1;
        check("async_reset", obs(), pk(0, 0, 0, 8'h00));
        INTR_IN = 8'h81;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        check("reset_release", obs(), pk(0, 0, 0, 8'h00));
        cnt = 0;
        lastid = 3'd0;
        for (int c = 0; c < 20; c++) begin
            step(8'h81, 8'hFF, 1, IRQ, BUSY);
            if (IRQ) begin
                cnt++;
                lastid = IRQ_ID;
            end
        end
        check("held_through_reset", 32'(cnt * 8) + 32'(lastid), 32'd15);

        // randomised traffic against the model
        nRST = 1'b0;
        step(IDLE_IN, 8'hFF, 1, 0, 0);
        nRST = 1'b1;
        rin   = IDLE_IN;
        rmask = 8'hFF;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                rin ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
            end
            if ($urandom_range(0, 31) == 0) begin
                rmask = 8'($urandom) | 8'($urandom);
            end
            step(rin, rmask, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            check($sformatf("rand[%0d]", c), obs(), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
